// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity selection and line levels.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Loadable LSB-first shift register with a saturating bit counter for the UART data phase.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_tx_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_shift_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic                  o_ser_bit,
    output logic                  o_ser_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  primed_q, primed_d;

    // The first shift after a load happens on entry to DATA and only clears the counter,
    // so the counter equals the index of the bit currently on the line.
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        if (i_load) begin
            shift_d  = i_data_in;
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (i_shift_en) begin
            shift_d = shift_q >> 1;
            if (!primed_q) begin
                primed_d = 1'b1;
                cnt_d    = '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
        end
    end

    assign o_ser_bit  = shift_q[0];
    assign o_ser_done = primed_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter clocked by the divider output: start, LSB-first data, optional parity, stop.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_tx_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_s_data,
    output logic                  o_busy
);

    tx_state_e state_q, state_d;
    logic      s_data_q, s_data_d;
    logic      busy_q, busy_d;
    logic      par_en_q, par_en_d;
    logic      par_bit_q, par_bit_d;
    logic      load, shift_en;
    logic      ser_bit, ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .i_tx_clk   (i_tx_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (load),
        .i_shift_en (shift_en),
        .i_data_in  (i_p_data),
        .o_ser_bit  (ser_bit),
        .o_ser_done (ser_done)
    );

    // Next-state logic also produces the next line level, so o_s_data is a flop output.
    always_comb begin
        state_d   = state_q;
        s_data_d  = s_data_q;
        busy_d    = busy_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE, STOP: begin
                if (i_data_valid) begin
                    state_d   = START;
                    s_data_d  = START_BIT;
                    busy_d    = 1'b1;
                    load      = 1'b1;
                    par_en_d  = i_par_en;
                    par_bit_d = (i_par_typ == PAR_EVEN) ? ^i_p_data : ~^i_p_data;
                end else begin
                    state_d  = IDLE;
                    s_data_d = IDLE_BIT;
                    busy_d   = 1'b0;
                end
            end
            START: begin
                state_d  = DATA;
                s_data_d = ser_bit;
                shift_en = 1'b1;
            end
            DATA: begin
                if (ser_done) begin
                    state_d  = par_en_q ? PARITY : STOP;
                    s_data_d = par_en_q ? par_bit_q : STOP_BIT;
                end else begin
                    s_data_d = ser_bit;
                    shift_en = 1'b1;
                end
            end
            PARITY: begin
                state_d  = STOP;
                s_data_d = STOP_BIT;
            end
            default: begin
                state_d  = IDLE;
                s_data_d = IDLE_BIT;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            s_data_q  <= IDLE_BIT;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_data_q  <= s_data_d;
            busy_q    <= busy_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign o_s_data = s_data_q;
    assign o_busy   = busy_q;

endmodule
